// File: rtl/pc_sequencer_if.sv
// Control/operand bundle between the instruction decoder (master) and the
// PC sequencer (slave), plus the PC-side status returned to fetch/debug.
interface pc_sequencer_if #(
    parameter int XLEN = 32
);
    logic            instr_valid;
    logic            Branch;
    logic            JAL;
    logic            pc_sel;
    logic            EC_FE;
    logic            EB;
    logic            branch_taken;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] alu_result;
    logic            resume;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            flush;
    logic            halted;
    logic            ecall_pulse;
    logic [31:0]     instret;

    modport master (
        output instr_valid, Branch, JAL, pc_sel, EC_FE, EB, branch_taken,
               imm, alu_result, resume,
        input  pc, pc_plus4, flush, halted, ecall_pulse, instret
    );

    modport slave (
        input  instr_valid, Branch, JAL, pc_sel, EC_FE, EB, branch_taken,
               imm, alu_result, resume,
        output pc, pc_plus4, flush, halted, ecall_pulse, instret
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC register, inserts a one-cycle
// flush bubble after every redirect, stops at EBREAK until the debugger
// resumes, and counts retired instructions.
module pc_sequencer #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_sequencer_if.slave bus
);
    typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instret_q, instret_d;
    logic            flush_q, halted_q, ecall_q, ecall_d;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_plus_imm;

    assign pc_plus4    = pc_q + XLEN'(4);
    assign pc_plus_imm = pc_q + bus.imm;

    // Register state, PC, counter and the status outputs derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            instret_q <= '0;
            flush_q   <= 1'b0;
            halted_q  <= 1'b0;
            ecall_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instret_q <= instret_d;
            flush_q   <= (state_d == FLUSH);
            halted_q  <= (state_d == HALT);
            ecall_q   <= ecall_d;
        end
    end

    // Next-state and next-PC decision; decoder word is only honoured in RUN.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instret_d = instret_q;
        ecall_d   = 1'b0;
        unique case (state_q)
            RUN: begin
                if (bus.instr_valid) begin
                    if (!bus.EB) begin
                        // PC stays on the EBREAK so the debugger sees it.
                        state_d = HALT;
                    end else begin
                        instret_d = instret_q + 32'd1;
                        ecall_d   = bus.EC_FE;
                        if (bus.pc_sel) begin
                            pc_d    = {bus.alu_result[XLEN-1:1], 1'b0};
                            state_d = FLUSH;
                        end else if (bus.JAL) begin
                            pc_d    = pc_plus_imm;
                            state_d = FLUSH;
                        end else if (bus.Branch && bus.branch_taken) begin
                            pc_d    = pc_plus_imm;
                            state_d = FLUSH;
                        end else begin
                            pc_d    = pc_plus4;
                        end
                    end
                end
            end
            FLUSH: begin
                state_d = RUN;
            end
            HALT: begin
                if (bus.resume) begin
                    pc_d    = pc_plus4;
                    state_d = FLUSH;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.flush       = flush_q;
    assign bus.halted      = halted_q;
    assign bus.ecall_pulse = ecall_q;
    assign bus.instret     = instret_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with RESET_PC = 0x100.
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    pc_sequencer_if #(.XLEN(32)) bus ();

    pc_sequencer #(.XLEN(32), .RESET_PC(32'h100)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic e_flush,
                           input logic e_halt, input logic e_ecall, input logic [31:0] e_ret);
        chk({tag, ".pc"},      bus.pc,          e_pc);
        chk({tag, ".flush"},   32'(bus.flush),  32'(e_flush));
        chk({tag, ".halted"},  32'(bus.halted), 32'(e_halt));
        chk({tag, ".ecall"},   32'(bus.ecall_pulse), 32'(e_ecall));
        chk({tag, ".instret"}, bus.instret,     e_ret);
    endtask

    task automatic drive(input logic v, input logic br, input logic jal, input logic ps,
                         input logic ec, input logic eb, input logic tk,
                         input logic [31:0] im, input logic [31:0] alu, input logic res);
        bus.instr_valid  = v;
        bus.Branch       = br;
        bus.JAL          = jal;
        bus.pc_sel       = ps;
        bus.EC_FE        = ec;
        bus.EB           = eb;
        bus.branch_taken = tk;
        bus.imm          = im;
        bus.alu_result   = alu;
        bus.resume       = res;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 0);
    endtask

    initial begin
        idle();
        cyc();
        cyc();
        chk_all("reset", 32'h100, 0, 0, 0, 0);
        chk("reset.pc_plus4", bus.pc_plus4, 32'h104);
        rst_n = 1'b1;

        // Three sequential instructions
        drive(1, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 0);
        cyc(); chk_all("seq1", 32'h104, 0, 0, 0, 1);
        cyc(); chk_all("seq2", 32'h108, 0, 0, 0, 2);
        cyc(); chk_all("seq3", 32'h10C, 0, 0, 0, 3);
        idle();
        cyc(); chk_all("idle_hold", 32'h10C, 0, 0, 0, 3);

        // JAL to 0x200, then taken branch presented during flush (ignored)
        drive(1, 1, 1, 0, 0, 1, 0, 32'hF4, 32'h0, 0);
        cyc(); chk_all("jal_to_200", 32'h200, 1, 0, 0, 4);
        drive(1, 1, 0, 0, 0, 1, 1, 32'hFFFF_FFF0, 32'h0, 0);
        cyc(); chk_all("flush_ignores", 32'h200, 0, 0, 0, 4);
        cyc(); chk_all("br_taken", 32'h1F0, 1, 0, 0, 5);
        idle();
        cyc(); chk_all("br_taken_after", 32'h1F0, 0, 0, 0, 5);

        // Back to 0x200, branch not taken
        drive(1, 1, 1, 0, 0, 1, 0, 32'h10, 32'h0, 0);
        cyc(); chk_all("jal_back_200", 32'h200, 1, 0, 0, 6);
        idle();
        cyc();
        drive(1, 1, 0, 0, 0, 1, 0, 32'hFFFF_FFF0, 32'h0, 0);
        cyc(); chk_all("br_not_taken", 32'h204, 0, 0, 0, 7);

        // To 0x300, JALR with Branch set
        drive(1, 1, 1, 0, 0, 1, 0, 32'hFC, 32'h0, 0);
        cyc(); chk_all("jal_to_300", 32'h300, 1, 0, 0, 8);
        idle();
        cyc();
        drive(1, 1, 0, 1, 0, 1, 0, 32'h40, 32'h1235, 0);
        cyc(); chk_all("jalr", 32'h1234, 1, 0, 0, 9);
        idle();
        cyc();
        drive(1, 1, 0, 1, 0, 1, 0, 32'h0, 32'h301, 0);
        cyc(); chk_all("jalr_clr_bit0", 32'h300, 1, 0, 0, 10);
        idle();
        cyc();
        drive(1, 1, 1, 0, 0, 1, 0, 32'h40, 32'h0, 0);
        cyc(); chk_all("jal_340", 32'h340, 1, 0, 0, 11);
        idle();
        cyc();

        // EBREAK at 0x400, ignored instructions, then resume
        drive(1, 1, 0, 1, 0, 1, 0, 32'h0, 32'h400, 0);
        cyc(); chk_all("jalr_400", 32'h400, 1, 0, 0, 12);
        idle();
        cyc();
        drive(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
        cyc(); chk_all("ebreak", 32'h400, 0, 1, 0, 12);
        drive(1, 1, 1, 0, 0, 1, 1, 32'h80, 32'h0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(); chk_all("halt_ignore", 32'h400, 0, 1, 0, 12);
        end
        drive(1, 1, 1, 0, 0, 1, 1, 32'h80, 32'h0, 1);
        cyc(); chk_all("resume", 32'h404, 1, 0, 0, 12);
        idle();
        cyc(); chk_all("resume_after", 32'h404, 0, 0, 0, 12);
        drive(0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 1);
        cyc(); chk_all("resume_in_run", 32'h404, 0, 0, 0, 12);

        // ECALL at 0x500
        drive(1, 1, 0, 1, 0, 1, 0, 32'h0, 32'h500, 0);
        cyc(); chk_all("jalr_500", 32'h500, 1, 0, 0, 13);
        idle();
        cyc();
        drive(1, 0, 0, 0, 1, 1, 0, 32'h0, 32'h0, 0);
        cyc(); chk_all("ecall", 32'h504, 0, 0, 1, 14);
        idle();
        cyc(); chk_all("ecall_after", 32'h504, 0, 0, 0, 14);

        // PC wrap
        drive(1, 1, 0, 1, 0, 1, 0, 32'h0, 32'hFFFF_FFFC, 0);
        cyc(); chk_all("jalr_top", 32'hFFFF_FFFC, 1, 0, 0, 15);
        chk("top.pc_plus4", bus.pc_plus4, 32'h0);
        idle();
        cyc();
        drive(1, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 0);
        cyc(); chk_all("wrap", 32'h0, 0, 0, 0, 16);
        chk("wrap.pc_plus4", bus.pc_plus4, 32'h4);

        // Asynchronous reset while in FLUSH
        drive(1, 1, 1, 0, 0, 1, 0, 32'h80, 32'h0, 0);
        cyc(); chk_all("jal_80", 32'h80, 1, 0, 0, 17);
        idle();
        #2 rst_n = 1'b0;
        #1 chk_all("rst_in_flush", 32'h100, 0, 0, 0, 0);
        cyc();
        rst_n = 1'b1;

        // Asynchronous reset while in HALT
        drive(1, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 0);
        cyc(); chk_all("seq_pre_halt", 32'h104, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
        cyc(); chk_all("halt2", 32'h104, 0, 1, 0, 1);
        idle();
        #2 rst_n = 1'b0;
        #1 chk_all("rst_in_halt", 32'h100, 0, 0, 0, 0);
        cyc();
        rst_n = 1'b1;

        // Reset kills a pending ecall pulse
        drive(1, 0, 0, 0, 1, 1, 0, 32'h0, 32'h0, 0);
        cyc(); chk_all("ecall2", 32'h104, 0, 0, 1, 1);
        idle();
        #2 rst_n = 1'b0;
        #1 chk_all("rst_ecall", 32'h100, 0, 0, 0, 0);
        cyc();
        rst_n = 1'b1;
        cyc(); chk_all("post_reset", 32'h100, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
